// File: rtl/alu_issue_seq.sv
// Single-issue RV32I integer sequencer: decodes one instruction at a time, hands
// operands to an external ALU, and writes the result back into a 32x32 register file.
module alu_issue_seq #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic        alu_modbit,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_rd,
  input  logic        alu_comp,
  output logic        retire,
  output logic [4:0]  retire_rd_addr,
  output logic [31:0] retire_data,
  output logic        illegal,
  output logic        timeout,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] instr_q;
  logic [7:0]  cnt;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm;
  logic        legal;
  logic        modbit;
  logic        sample;
  logic        expire;

  assign opcode  = instr_q[6:0];
  assign funct3  = instr_q[14:12];
  assign funct7  = instr_q[31:25];
  assign rd_idx  = instr_q[11:7];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign imm     = {{20{instr_q[31]}}, instr_q[31:20]};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0);
          3'b101:  legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_REG: legal = (funct7 == 7'b0) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      default: legal = 1'b0;
    endcase
  end

  // Bit 30 selects SUB/SRA/SRAI; it is part of the immediate for every other I-type op.
  assign modbit = ((opcode == OP_REG) || ((opcode == OP_IMM) && (funct3 == 3'b101)))
                  ? instr_q[30] : 1'b0;

  // The ALU output is registered, so the first CAPTURE cycle still shows a stale result.
  assign sample = (state == CAPTURE) && (cnt != 8'd0) && alu_comp;
  assign expire = (state == CAPTURE) && !sample && (cnt == CNT_LAST);

  assign instr_ready = (state == IDLE) && !rst;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would make ordering inside the block matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      instr_q        <= '0;
      cnt            <= '0;
      alu_opcode     <= '0;
      alu_funct3     <= '0;
      alu_modbit     <= 1'b0;
      alu_imm        <= '0;
      alu_rs1        <= '0;
      alu_rs2        <= '0;
      retire         <= 1'b0;
      retire_rd_addr <= '0;
      retire_data    <= '0;
      illegal        <= 1'b0;
      timeout        <= 1'b0;
      // NOTE: the register file is reset explicitly because reset must clear x1..x31;
      // this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire         <= 1'b0;
      illegal        <= 1'b0;
      timeout        <= 1'b0;
      retire_rd_addr <= '0;
      retire_data    <= '0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (legal) begin
            alu_opcode <= opcode;
            alu_funct3 <= funct3;
            alu_modbit <= modbit;
            alu_imm    <= imm;
            alu_rs1    <= (rs1_idx == 5'd0) ? 32'd0 : rf[rs1_idx];
            alu_rs2    <= (rs2_idx == 5'd0) ? 32'd0 : rf[rs2_idx];
            state      <= ISSUE;
          end else begin
            illegal <= 1'b1;
            state   <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (sample) begin
            if (rd_idx != 5'd0) rf[rd_idx] <= alu_rd;
            retire         <= 1'b1;
            retire_rd_addr <= rd_idx;
            retire_data    <= alu_rd;
            alu_opcode     <= '0;
            state          <= IDLE;
          end else if (expire) begin
            timeout    <= 1'b1;
            alu_opcode <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: a behavioural one-cycle ALU, a vector table of
// instructions with hand-computed results, then timeout and mid-instruction reset cases.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_modbit;
  logic [31:0] alu_imm;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_rd;
  logic        alu_comp;
  logic        retire;
  logic [4:0]  retire_rd_addr;
  logic [31:0] retire_data;
  logic        illegal;
  logic        timeout;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_seq #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_modbit(alu_modbit), .alu_imm(alu_imm), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd), .alu_comp(alu_comp), .retire(retire),
    .retire_rd_addr(retire_rd_addr), .retire_data(retire_data), .illegal(illegal),
    .timeout(timeout), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU with one registered cycle of latency; alu_en=0 starves the sequencer.
  logic alu_en;
  always @(posedge clk) begin
    if (alu_en && alu_opcode != 7'd0) begin
      alu_comp <= 1'b1;
      case ({alu_opcode, alu_funct3})
        {7'b0110011, 3'b000}: alu_rd <= alu_modbit ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
        {7'b0010011, 3'b000}: alu_rd <= alu_rs1 + alu_imm;
        {7'b0010011, 3'b100}: alu_rd <= alu_rs1 ^ alu_imm;
        {7'b0010011, 3'b101}: alu_rd <= alu_modbit ? 32'($signed(alu_rs1) >>> alu_imm[4:0])
                                                   : alu_rs1 >> alu_imm[4:0];
        default:              alu_rd <= 32'hDEAD_BEEF;
      endcase
    end else begin
      alu_comp <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Pulses must never overlap nor appear on consecutive cycles.
  int   pulse_viol = 0;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if ((32'(retire) + 32'(illegal) + 32'(timeout)) > 1) pulse_viol++;
      if (prev_pulse && (retire || illegal || timeout)) pulse_viol++;
      prev_pulse <= retire || illegal || timeout;
    end
  end

  logic [31:0] seen_rs1, seen_rs2;
  logic        seen_mod;

  // kind: 0 retire, 1 illegal, 2 timeout, 3 nothing within the cycle budget
  task automatic send(input logic [31:0] w, output int kind, output logic [4:0] rd_o,
                      output logic [31:0] data_o, output int n);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    n    = 1;
    kind = 3;
    rd_o   = 'x;
    data_o = 'x;
    while (kind == 3 && n < 40) begin
      if (retire) begin
        kind = 0; rd_o = retire_rd_addr; data_o = retire_data;
      end else if (illegal) begin
        kind = 1;
      end else if (timeout) begin
        kind = 2;
      end else begin
        if (alu_opcode != 7'd0) begin
          seen_rs1 = alu_rs1; seen_rs2 = alu_rs2; seen_mod = alu_modbit;
        end
        @(negedge clk);
        n++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] w;
    int          kind;
    int          lat;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] dbg;
    bit          chk_ops;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        mod;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          kind, n;
    logic [4:0]  rd_o;
    logic [31:0] data_o;
    int          rcount;

    vecs[0]  = '{32'h00500093, 0, 5, 5'd1, 32'h00000005, 32'h00000005, 0, 0, 0, 0};
    vecs[1]  = '{32'hFFD00113, 0, 5, 5'd2, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 0, 0, 0};
    vecs[2]  = '{32'h002081B3, 0, 5, 5'd3, 32'h00000002, 32'h00000002, 1, 5, 32'hFFFFFFFD, 0};
    vecs[3]  = '{32'h40208233, 0, 5, 5'd4, 32'h00000008, 32'h00000008, 1, 5, 32'hFFFFFFFD, 1};
    vecs[4]  = '{32'h00700013, 0, 5, 5'd0, 32'h00000007, 32'h00000000, 0, 0, 0, 0};
    vecs[5]  = '{32'h00000073, 1, 2, 5'd4, 32'h0, 32'h00000008, 0, 0, 0, 0};
    vecs[6]  = '{32'h40201033, 1, 2, 5'd4, 32'h0, 32'h00000008, 0, 0, 0, 0};
    vecs[7]  = '{32'h02109093, 1, 2, 5'd1, 32'h0, 32'h00000005, 0, 0, 0, 0};
    vecs[8]  = '{32'h021080B3, 1, 2, 5'd1, 32'h0, 32'h00000005, 0, 0, 0, 0};
    vecs[9]  = '{32'h0FF0C293, 0, 5, 5'd5, 32'h000000FA, 32'h000000FA, 0, 0, 0, 0};
    vecs[10] = '{32'h4010D313, 0, 5, 5'd6, 32'h00000002, 32'h00000002, 1, 5, 5, 1};
    vecs[11] = '{32'h00208393, 0, 5, 5'd7, 32'h00000007, 32'h00000007, 0, 0, 0, 0};

    rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_en = 1'b1; dbg_addr = 5'd1;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(instr_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(instr_ready), 1);
    check("reset_retire", 32'(retire), 0);
    check("reset_opcode", 32'(alu_opcode), 0);
    check("reset_dbg_x1", dbg_data, 0);

    foreach (vecs[i]) begin
      send(vecs[i].w, kind, rd_o, data_o, n);
      check($sformatf("v%0d_kind", i), 32'(kind), 32'(vecs[i].kind));
      check($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      check($sformatf("v%0d_ready", i), 32'(instr_ready), 1);
      if (vecs[i].kind == 0) begin
        check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(vecs[i].rd));
        check($sformatf("v%0d_data", i), data_o, vecs[i].data);
      end
      if (vecs[i].chk_ops) begin
        check($sformatf("v%0d_rs1", i), seen_rs1, vecs[i].rs1);
        check($sformatf("v%0d_rs2", i), seen_rs2, vecs[i].rs2);
        check($sformatf("v%0d_modbit", i), 32'(seen_mod), 32'(vecs[i].mod));
      end
      dbg_addr = vecs[i].rd;
      #1;
      check($sformatf("v%0d_dbg", i), dbg_data, vecs[i].dbg);
    end

    // Starved ALU: 8 CAPTURE cycles after DECODE and ISSUE, pulse on the 11th.
    alu_en = 1'b0;
    send(32'h00100413, kind, rd_o, data_o, n);  // ADDI x8,x0,1
    check("to_kind", 32'(kind), 2);
    check("to_latency", 32'(n), 11);
    check("to_ready", 32'(instr_ready), 1);
    dbg_addr = 5'd8;
    #1;
    check("to_dbg_x8", dbg_data, 0);
    alu_en = 1'b1;

    // Reset during CAPTURE of ADDI x5,x0,9 aborts without writeback.
    @(negedge clk);
    instr = 32'h00900293; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_opcode", 32'(alu_opcode), 32'h13);
    rst = 1'b1;
    #1;
    dbg_addr = 5'd5;
    #1;
    check("rst_retire", 32'(retire), 0);
    check("rst_opcode", 32'(alu_opcode), 0);
    check("rst_rs1", alu_rs1, 0);
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_dbg_x5", dbg_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(instr_ready), 1);
    rcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (retire) rcount++;
    end
    check("rst_no_retire", 32'(rcount), 0);
    dbg_addr = 5'd1;
    #1;
    check("rst_dbg_x1", dbg_data, 0);
    check("pulse_exclusive", 32'(pulse_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 SHALL have parameter: TIMEOUT, 8, max CAPTURE cycles waiting for alu_comp before abort (1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: instr  input  32  RV32I instruction word.
REQ-005 SHALL have port: instr_valid  input  1  instr presented.
REQ-006 SHALL have port: instr_ready  output  1  block accepts instr this cycle.
REQ-007 SHALL have ports to ALU: alu_opcode out 7, alu_funct3 out 3, alu_modbit out 1, alu_imm out 32, alu_rs1 out 32, alu_rs2 out 32, all registered.
REQ-008 SHALL have ports from ALU: alu_rd  input  32  result; alu_comp  input  1  result-valid level.
REQ-009 SHALL have port: retire  output  1  one-cycle pulse, instruction completed.
REQ-010 SHALL have ports: retire_rd_addr out 5, retire_data out 32  destination/value of retiring instruction.
REQ-011 SHALL have port: illegal  output  1  one-cycle pulse, instruction rejected.
REQ-012 SHALL have port: timeout  output  1  one-cycle pulse, ALU did not complete.
REQ-013 SHALL have ports: dbg_addr in 5, dbg_data out 32  combinational register-file read.

Function
REQ-014 SHALL contain 32x32 register file; x0 reads 0, writes to x0 discarded.
REQ-015 SHALL implement FSM IDLE -> DECODE -> ISSUE -> CAPTURE -> IDLE.
REQ-016 instr_ready SHALL be 1 only in IDLE; instr_valid&instr_ready latches instr and enters DECODE.
REQ-017 DECODE SHALL read rs1=instr[19:15], rs2=instr[24:20], form imm = sign-extended instr[31:20], check legality.
REQ-018 Legal: opcode 0010011 (funct3 001 needs instr[31:25]=0000000; 101 needs 0000000/0100000) or opcode 0110011 (funct7 0000000 any funct3; 0100000 only funct3 000/101); all else illegal.
REQ-019 Illegal in DECODE SHALL pulse illegal next cycle, return to IDLE, no write, no retire.
REQ-020 alu_modbit SHALL be instr[30] for opcode 0110011 and for 0010011 with funct3 101, else 0.
REQ-021 ISSUE SHALL drive alu_* with decoded values; held stable through CAPTURE; alu_opcode=0 and alu_imm/rs1/rs2 hold last value in all other states.
REQ-022 CAPTURE first cycle SHALL not sample (ALU has one-cycle registered latency); from second CAPTURE cycle on, alu_comp=1 samples alu_rd.
REQ-023 On sample SHALL write alu_rd to x[instr[11:7]] (unless 0), pulse retire with retire_rd_addr/retire_data, return IDLE.
REQ-024 CAPTURE cycle counter SHALL start at 0; if it reaches TIMEOUT without sample, pulse timeout, no write, return IDLE.
REQ-025 Throughput: minimum 5 cycles accept-to-next-accept; back-to-back dependent instructions SHALL see prior write (no hazard logic needed).
REQ-026 instr_valid outside IDLE SHALL be ignored; instr value may change freely after acceptance.
REQ-027 retire, illegal, timeout SHALL be mutually exclusive, never high two consecutive cycles.

Reset
REQ-028 rst SHALL immediately force IDLE, all registers x1..x31 = 0, counter 0, all outputs 0 except instr_ready=1 after reset deasserts.
REQ-029 rst mid-instruction SHALL abort it: no writeback, no retire pulse.

Verification
REQ-030 ADDI x1,x0,5 (0x00500093) then ADDI x2,x0,-3 (0xFFD00113) -> retire with (1,0x00000005), (2,0xFFFFFFFD); dbg x1=5, x2=0xFFFFFFFD.
REQ-031 Then ADD x3,x1,x2 (0x002081B3) -> alu_rs1=5, alu_rs2=0xFFFFFFFD, modbit 0, x3=2; SUB x4,x1,x2 (0x40208233) -> modbit 1, x4=8.
REQ-032 ADDI x0,x0,7 (0x00700013) -> retire pulse, retire_rd_addr 0, dbg x0 stays 0.
REQ-033 ECALL 0x00000073 and 0x40201033 (SLL with funct7 0100000) -> illegal pulse each, no retire, register file unchanged.
REQ-034 alu_comp held 0 with TIMEOUT=8 -> timeout pulse exactly after 8 CAPTURE cycles, no write, instr_ready=1 next cycle.
REQ-035 rst asserted during CAPTURE of ADDI x5,x0,9 -> no retire, x5=0, outputs 0, IDLE after release.
